// File: rtl/reg_scan_bank.sv
`default_nettype none
// ============================================================================
// Module   : reg_scan_bank
// Brief    : Register bank feeding an external Mux select tree, plus a scan
//            sequencer that streams a wrapping range of entries out via
//            valid/ready.
// Revision : 1.0 - initial release
// ============================================================================
module reg_scan_bank #(
    parameter int switch_bits = 1,
    parameter int data_width  = 8
) (
    input  logic                                      clk,
    input  logic                                      rst,
    input  logic                                      wr_en,
    input  logic [switch_bits-1:0]                    wr_addr,
    input  logic [data_width-1:0]                     wr_data,
    input  logic                                      start,
    input  logic [switch_bits-1:0]                    first,
    input  logic [switch_bits:0]                      len,
    output logic [(1<<switch_bits)*data_width-1:0]    bank_flat,
    output logic [switch_bits-1:0]                    sel,
    input  logic [data_width-1:0]                     mux_o,
    output logic                                      out_valid,
    input  logic                                      out_ready,
    output logic [data_width-1:0]                     out_data,
    output logic [switch_bits-1:0]                    out_addr,
    output logic                                      busy,
    output logic                                      done
);

    localparam int                 c_depth   = 1 << switch_bits;
    localparam logic [switch_bits:0] c_len_max = (switch_bits+1)'(c_depth);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_OUT  = 2'd2,
        S_FIN  = 2'd3
    } state_t;

    state_t                  r_state;
    logic [data_width-1:0]   r_bank [c_depth];
    logic [switch_bits-1:0]  r_sel;
    logic [switch_bits:0]    r_remaining;
    logic                    r_out_valid;
    logic [data_width-1:0]   r_out_data;
    logic [switch_bits-1:0]  r_out_addr;
    logic [switch_bits:0]    w_len_clamped;

    assign w_len_clamped = (len > c_len_max) ? c_len_max : len;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < c_depth; i++) begin
                r_bank[i] <= '0;
            end
        end else if (wr_en) begin
            r_bank[wr_addr] <= wr_data;
        end
    end

    generate
        for (genvar gi = 0; gi < c_depth; gi++) begin : g_flat
            assign bank_flat[gi*data_width +: data_width] = r_bank[gi];
        end
    endgenerate

    // mux_o is driven from the registered bank, so a write landing on the
    // LOAD edge is not visible to that capture.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= S_IDLE;
            r_sel       <= '0;
            r_remaining <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_addr  <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_sel       <= first;
                        r_remaining <= w_len_clamped;
                        r_state     <= (w_len_clamped == '0) ? S_FIN : S_LOAD;
                    end
                end
                S_LOAD: begin
                    r_out_data  <= mux_o;
                    r_out_addr  <= r_sel;
                    r_out_valid <= 1'b1;
                    r_remaining <= r_remaining - 1'b1;
                    r_state     <= S_OUT;
                end
                S_OUT: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        if (r_remaining == '0) begin
                            r_state <= S_FIN;
                        end else begin
                            r_sel   <= r_sel + 1'b1;
                            r_state <= S_LOAD;
                        end
                    end
                end
                S_FIN: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign sel       = r_sel;
    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_addr  = r_out_addr;
    assign busy      = (r_state != S_IDLE);
    assign done      = (r_state == S_FIN);

endmodule
`default_nettype wire

// File: tb/tb_reg_scan_bank.sv
`default_nettype none
// ============================================================================
// Module   : tb_reg_scan_bank
// Brief    : Directed bench for reg_scan_bank with a transaction-level model
//            of the bank and scan stream checked every cycle.
// Revision : 1.0 - initial release
// ============================================================================
module tb_reg_scan_bank;

    localparam int SB    = 2;
    localparam int DW    = 8;
    localparam int DEPTH = 4;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              wr_en = 1'b0;
    logic [SB-1:0]     wr_addr = '0;
    logic [DW-1:0]     wr_data = '0;
    logic              start = 1'b0;
    logic [SB-1:0]     first = '0;
    logic [SB:0]       len = '0;
    logic              out_ready = 1'b0;
    logic [DEPTH*DW-1:0] bank_flat;
    logic [SB-1:0]     sel;
    logic [DW-1:0]     mux_o;
    logic              out_valid;
    logic [DW-1:0]     out_data;
    logic [SB-1:0]     out_addr;
    logic              busy;
    logic              done;

    always #5 clk = ~clk;

    // Behaviour of the downstream Mux: pure select from the flattened bank.
    assign mux_o = bank_flat[int'(sel)*DW +: DW];

    reg_scan_bank #(.switch_bits(SB), .data_width(DW)) dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .start(start), .first(first), .len(len), .bank_flat(bank_flat), .sel(sel),
        .mux_o(mux_o), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_addr(out_addr), .busy(busy), .done(done)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h required 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- model ----------------
    logic [DW-1:0] m_bank [DEPTH];
    logic [DW-1:0] bank_before [DEPTH];
    bit            m_busy, m_fin_pending;
    int            m_first, m_len, m_k;
    bit            last_valid;
    logic [DW-1:0] last_data;
    logic [SB-1:0] last_addr;
    logic [DW-1:0] got_data [$];
    logic [SB-1:0] got_addr [$];

    function automatic logic [DEPTH*DW-1:0] model_flat();
        logic [DEPTH*DW-1:0] f;
        for (int i = 0; i < DEPTH; i++) f[i*DW +: DW] = m_bank[i];
        return f;
    endfunction

    initial begin
        bit s_start, s_ready, acc, hs, exp_done;
        int s_first, s_len, ea;
        forever begin
            @(posedge clk);
            if (!rst) begin
                for (int i = 0; i < DEPTH; i++) m_bank[i] = '0;
                m_busy = 0; m_fin_pending = 0; last_valid = 0;
            end else begin
                s_start = start; s_first = int'(first); s_len = int'(len); s_ready = out_ready;
                bank_before = m_bank;
                if (wr_en) m_bank[wr_addr] = wr_data;
                #1;
                if (rst) begin
                    exp_done = 0;
                    acc = s_start && !m_busy;
                    if (m_fin_pending) begin m_busy = 0; m_fin_pending = 0; end
                    if (acc) begin
                        m_busy = 1; m_first = s_first; m_k = 0;
                        m_len = (s_len > DEPTH) ? DEPTH : s_len;
                        if (m_len == 0) begin exp_done = 1; m_fin_pending = 1; end
                    end
                    hs = last_valid && s_ready;
                    if (hs) begin
                        m_k++;
                        got_data.push_back(last_data);
                        got_addr.push_back(last_addr);
                        check("valid_low_after_handshake", out_valid, 0);
                        if (m_k == m_len) begin exp_done = 1; m_fin_pending = 1; end
                    end else if (last_valid) begin
                        check("stall_valid_held", out_valid, 1);
                        check("stall_data_held", out_data, last_data);
                        check("stall_addr_held", out_addr, last_addr);
                    end else if (out_valid) begin
                        ea = (m_first + m_k) % DEPTH;
                        check("word_expected", (m_busy && m_k < m_len), 1);
                        check("word_addr", out_addr, ea);
                        check("word_data", out_data, bank_before[ea]);
                    end
                    check("done", done, exp_done);
                    check("busy", busy, m_busy);
                    check("bank_flat", bank_flat, model_flat());
                    last_valid = out_valid; last_data = out_data; last_addr = out_addr;
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic idle_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic write(input int a, input int d);
        @(negedge clk);
        wr_en = 1'b1; wr_addr = SB'(a); wr_data = DW'(d);
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    // Returns edges counted from the start-sampling edge up to the done cycle.
    task automatic run_scan(input int f, input int l, input int max, output int n);
        @(negedge clk);
        start = 1'b1; first = SB'(f); len = (SB+1)'(l);
        n = 0;
        while (n < max) begin
            @(posedge clk); #1;
            n++;
            if (n == 1) start = 1'b0;
            if (done) break;
        end
        if (!done) check("scan_timeout", n, 0);
    endtask

    task automatic check_seq(input string name, input int cnt, input logic [31:0] ed, input logic [7:0] ea);
        check({name, "_count"}, got_data.size(), cnt);
        for (int i = 0; i < cnt && i < got_data.size(); i++) begin
            check({name, "_data"}, got_data[i], ed[i*8 +: 8]);
            check({name, "_addr"}, got_addr[i], ea[i*2 +: 2]);
        end
    endtask

    task automatic clear_got();
        got_data.delete();
        got_addr.delete();
    endtask

    initial begin
        int n;
        #12;
        check("rst_out_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_sel", sel, 0);
        check("rst_out_data", out_data, 0);
        check("rst_out_addr", out_addr, 0);
        check("rst_bank", bank_flat, 0);
        @(negedge clk); rst = 1'b1;

        write(0, 8'h11); write(1, 8'h22); write(2, 8'h33); write(3, 8'h44);
        idle_cycles(1);
        check("bank_after_writes", bank_flat, 64'h44332211);

        // Full scan, ready tied high
        out_ready = 1'b1; clear_got();
        run_scan(0, 4, 40, n);
        check("full_cycles", n, 9);
        check_seq("full", 4, 32'h44332211, {2'd3, 2'd2, 2'd1, 2'd0});
        idle_cycles(2);

        // Wrap with 3-cycle stalls per word
        out_ready = 1'b0; clear_got();
        fork
            run_scan(3, 3, 200, n);
            begin
                for (int w = 0; w < 3; w++) begin
                    int t = 0;
                    while (t < 50) begin
                        @(posedge clk); #1; t++;
                        if (out_valid) break;
                    end
                    if (!out_valid) check("wrap_valid_timeout", t, 0);
                    repeat (3) @(negedge clk);
                    @(negedge clk); out_ready = 1'b1;
                    @(negedge clk); out_ready = 1'b0;
                end
            end
        join
        check_seq("wrap", 3, {8'h00, 8'h22, 8'h11, 8'h44}, {2'd0, 2'd1, 2'd0, 2'd3});
        idle_cycles(2);

        // len beyond DEPTH is clamped
        out_ready = 1'b1; clear_got();
        run_scan(2, 7, 40, n);
        check("clamp_cycles", n, 9);
        check_seq("clamp", 4, 32'h22114433, {2'd1, 2'd0, 2'd3, 2'd2});
        idle_cycles(2);

        // Zero length
        clear_got();
        run_scan(2, 0, 10, n);
        check("zero_len_cycles", n, 1);
        check("zero_len_words", got_data.size(), 0);
        idle_cycles(3);
        check("zero_len_no_valid", out_valid, 0);

        // Start pulsed mid-scan is ignored
        clear_got();
        fork
            run_scan(0, 4, 40, n);
            begin
                repeat (4) @(negedge clk);
                start = 1'b1; first = 2'd2; len = 3'd1;
                @(negedge clk); start = 1'b0;
            end
        join
        check("ignored_start_cycles", n, 9);
        check_seq("ignored_start", 4, 32'h44332211, {2'd3, 2'd2, 2'd1, 2'd0});
        idle_cycles(2);

        // Collision: write at LOAD of entry 1, and ahead of entry 2's LOAD
        clear_got();
        fork
            run_scan(1, 2, 40, n);
            begin
                @(negedge clk);
                @(negedge clk); wr_en = 1'b1; wr_addr = 2'd1; wr_data = 8'hAA;
                @(negedge clk); wr_addr = 2'd2; wr_data = 8'hBB;
                @(negedge clk); wr_en = 1'b0;
            end
        join
        check_seq("collision", 2, {16'h0, 8'hBB, 8'h22}, {4'd0, 2'd2, 2'd1});
        idle_cycles(2);
        check("collision_bank1", bank_flat[15:8], 8'hAA);
        check("collision_bank2", bank_flat[23:16], 8'hBB);

        // Mid-scan reset while stalled
        out_ready = 1'b0;
        @(negedge clk); start = 1'b1; first = 2'd1; len = 3'd4;
        begin
            int t = 0;
            while (t < 20) begin
                @(posedge clk); #1; t++;
                start = 1'b0;
                if (out_valid) break;
            end
            check("midrst_valid_seen", out_valid, 1);
        end
        #2; rst = 1'b0; #1;
        check("midrst_out_valid", out_valid, 0);
        check("midrst_busy", busy, 0);
        check("midrst_sel", sel, 0);
        check("midrst_bank", bank_flat, 0);
        check("midrst_out_data", out_data, 0);
        check("midrst_done", done, 0);
        @(posedge clk);
        @(negedge clk); rst = 1'b1; out_ready = 1'b1;
        repeat (6) begin
            @(posedge clk); #1;
            check("midrst_no_done", done, 0);
            check("midrst_idle", busy, 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire

// File: doc/reg_scan_bank.md
# reg_scan_bank

Register bank plus scan sequencer that sits directly upstream of the `Mux` select tree in `proc/`. It holds `2**switch_bits` words, presents them flattened to the `Mux` data inputs, and drives the `Mux` select. It captures the `Mux` output and streams a requested range of entries out through a valid/ready handshake. Writes are accepted at any time, including mid-scan.

## Interface
- `switch_bits`, 1, select width; the bank depth is `DEPTH = 2**switch_bits`.
- `data_width`, 8, word width.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `wr_en` in 1: write strobe.
- `wr_addr` in `switch_bits`: write index.
- `wr_data` in `data_width`: write word.
- `start` in 1: begin a scan; sampled only in IDLE.
- `first` in `switch_bits`: first entry of the scan; sampled with `start`.
- `len` in `switch_bits+1`: number of entries to emit, 0..DEPTH; sampled with `start`.
- `bank_flat` out `DEPTH*data_width`: entry i is on bits `[i*data_width +: data_width]`; goes to the `Mux` inputs.
- `sel` out `switch_bits`: registered select; goes to `Mux` `q`.
- `mux_o` in `data_width`: `Mux` output, combinational from `bank_flat`/`sel`.
- `out_valid` out 1, `out_ready` in 1, `out_data` out `data_width`, `out_addr` out `switch_bits`: output stream.
- `busy` out 1: high in any state other than IDLE.
- `done` out 1: one-cycle pulse when a scan finishes.

## Operation
- Reset (`rst`=0, asynchronous) puts the block in this state:
  - all bank entries 0, `sel`=0, `out_data`=0, `out_addr`=0;
  - `out_valid`=0, `busy`=0, `done`=0, remaining=0, FSM=IDLE.
- Write: on a clk edge with `wr_en`=1, `bank[wr_addr] <= wr_data`. Writes are legal in every state and never stall.
- FSM states are IDLE, LOAD, OUT, FIN.
- IDLE:
  - On `start`=1, `sel <= first` and `remaining <= len`.
  - If `len`=0, go to FIN; otherwise go to LOAD.
  - `start` in any other state is ignored.
- LOAD:
  - `out_data <= mux_o`, `out_addr <= sel`, `out_valid <= 1`.
  - `remaining <= remaining-1`; go to OUT.
- OUT:
  - Hold `out_valid`/`out_data`/`out_addr` stable until `out_ready`=1.
  - On the handshake, `out_valid <= 0`.
  - If `remaining`=0, go to FIN.
  - Otherwise `sel <= sel+1` (mod DEPTH, wrapping DEPTH-1 -> 0) and go to LOAD.
- FIN: `done`=1 for this single cycle; next state IDLE.
- Address arithmetic is modulo DEPTH. A range `first..first+len-1` crossing DEPTH-1 wraps to 0. `len`=DEPTH emits every entry exactly once.
- `len` > DEPTH is clamped to DEPTH.
- Write/capture collision: a write to `bank[sel]` in the same cycle as LOAD captures the old value, because `mux_o` reflects the registered bank. A write to an entry not yet loaded is seen by its later LOAD.
- `sel` is held after a scan; it changes only on `start` or when a scan advances.

## Timing
- `start` at edge t puts the FSM in LOAD during cycle t+1. The first `out_valid`=1 is after edge t+1.
- With `out_ready` tied to 1, the scan emits one word every 2 cycles. N words take 2N cycles from `start` to the final handshake, and `done` is high in the cycle after the final handshake.
- `len`=0: `done` is high in the cycle after `start`, and no `out_valid` is produced.
- `bank_flat` updates the cycle after the write edge. There is no bypass from `wr_data`.
- `out_valid` never drops without a handshake, except on reset.
- Mid-scan reset: all outputs take their reset values immediately (asynchronously). No `done` is produced, and the bank is cleared.

## Test plan
Settings: `switch_bits`=2, `data_width`=8.
- Reset/write: assert `rst`=0, release, then write 0x11,0x22,0x33,0x44 to entries 0..3. Required: `bank_flat`=0x44332211, and all outputs were 0 during reset.
- Full scan: `start` with `first`=0, `len`=4, `out_ready`=1. Required: words 0x11,0x22,0x33,0x44 with `out_addr` 0..3, one word every 2 cycles, then a single `done` pulse.
- Wrap plus backpressure: `first`=3, `len`=3, `out_ready` low for 3 cycles on each word. Required: 0x44,0x11,0x22 with `out_addr` 3,0,1, and data held stable while stalled.
- Collision: scan `first`=1, `len`=2. In the LOAD cycle of entry 1, write 0xAA to entry 1; also write 0xBB to entry 2 before its LOAD. Required: emitted 0x22, then 0xBB; `bank[1]`=0xAA afterwards.
- Zero length and ignored start: `len`=0 gives `done` one cycle later and no valid. A `start` pulsed during a running scan leaves the word sequence unchanged.
- Mid-scan reset: assert `rst` while `out_valid`=1 and stalled. Required: `out_valid`, `busy`, `sel` and the bank are 0 at once; after release no `done` appears and the FSM is in IDLE.
